// File: rtl/pkt_port_steer_if.sv
// Stream bundle for the port steerer: one AXI-Stream input, NUM_CH packed AXI-Stream outputs.
// Latency: none (wires only).
// Backpressure: s_axis_tready from the steerer, m_axis_tready per output channel from sinks.
interface pkt_port_steer_if #(
    parameter int DATA_W = 512,
    parameter int USER_W = 128,
    parameter int NUM_CH = 4
);
    logic [DATA_W-1:0]          s_axis_tdata;
    logic [DATA_W/8-1:0]        s_axis_tkeep;
    logic [USER_W-1:0]          s_axis_tuser;
    logic                       s_axis_tvalid;
    logic                       s_axis_tlast;
    logic                       s_axis_tready;

    logic [NUM_CH*DATA_W-1:0]   m_axis_tdata;
    logic [NUM_CH*DATA_W/8-1:0] m_axis_tkeep;
    logic [NUM_CH*USER_W-1:0]   m_axis_tuser;
    logic [NUM_CH-1:0]          m_axis_tvalid;
    logic [NUM_CH-1:0]          m_axis_tlast;
    logic [NUM_CH-1:0]          m_axis_tready;

    // Steerer view
    modport slave (
        input  s_axis_tdata, s_axis_tkeep, s_axis_tuser, s_axis_tvalid, s_axis_tlast,
        output s_axis_tready,
        output m_axis_tdata, m_axis_tkeep, m_axis_tuser, m_axis_tvalid, m_axis_tlast,
        input  m_axis_tready
    );

    // Source/sink environment view
    modport master (
        output s_axis_tdata, s_axis_tkeep, s_axis_tuser, s_axis_tvalid, s_axis_tlast,
        input  s_axis_tready,
        input  m_axis_tdata, m_axis_tkeep, m_axis_tuser, m_axis_tvalid, m_axis_tlast,
        output m_axis_tready
    );
endinterface

// File: rtl/pkt_port_steer.sv
// Steers IPv4/UDP packets to an output channel by destination port; others go to channel 0 or are dropped.
// Latency: 2 cycles from input handshake to output tvalid when idle and unblocked.
// Backpressure: input FIFO deasserts s_axis_tready near full; a packet waits for its channel's output register.
module pkt_port_steer #(
    parameter int C_S_AXIS_DATA_WIDTH  = 512,
    parameter int C_S_AXIS_TUSER_WIDTH = 128,
    parameter int NUM_CH               = 4,
    parameter int FIFO_DEPTH_BITS      = 5,
    parameter int CHK_L3               = 1,
    parameter int DROP_UNMATCHED       = 0
) (
    input  logic                       clk,
    input  logic                       aresetn,
    pkt_port_steer_if.slave            axis,
    input  logic [(NUM_CH-1)*16-1:0]   cfg_port,
    input  logic [NUM_CH-2:0]          cfg_en,
    output logic [31:0]                drop_cnt
);
    localparam int W     = C_S_AXIS_DATA_WIDTH;
    localparam int U     = C_S_AXIS_TUSER_WIDTH;
    localparam int K     = W / 8;
    localparam int DEPTH = 1 << FIFO_DEPTH_BITS;
    localparam int CHW   = $clog2(NUM_CH);

    localparam logic [FIFO_DEPTH_BITS-1:0] PTR_ONE = 1;
    localparam logic [FIFO_DEPTH_BITS:0]   CNT_ONE = 1;
    // One slot of headroom: ready is registered, so it lags the count by a cycle.
    localparam logic [FIFO_DEPTH_BITS:0]   CNT_NF  = DEPTH - 1;

    typedef struct packed {
        logic         last;
        logic [K-1:0] keep;
        logic [U-1:0] user;
        logic [W-1:0] data;
    } beat_t;

    typedef enum logic [1:0] {S_IDLE, S_FWD, S_DROP} state_t;

    // ---------------- input FIFO (first-word fallthrough) ----------------
    beat_t                      fifo_mem [DEPTH];
    logic [FIFO_DEPTH_BITS-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [FIFO_DEPTH_BITS:0]   cnt_q, cnt_d;
    logic                       in_rdy_q, in_rdy_d;
    logic                       wr_en, pop, not_empty;
    beat_t                      in_beat, head;

    assign in_beat   = '{last: axis.s_axis_tlast, keep: axis.s_axis_tkeep,
                         user: axis.s_axis_tuser, data: axis.s_axis_tdata};
    assign wr_en     = axis.s_axis_tvalid && in_rdy_q;
    assign not_empty = (cnt_q != '0);
    assign head      = fifo_mem[rd_ptr_q];
    assign axis.s_axis_tready = in_rdy_q;

    // Next FIFO pointers, occupancy and registered not-nearly-full ready
    always_comb begin
        wr_ptr_d = wr_en ? wr_ptr_q + PTR_ONE : wr_ptr_q;
        rd_ptr_d = pop   ? rd_ptr_q + PTR_ONE : rd_ptr_q;
        case ({wr_en, pop})
            2'b10:   cnt_d = cnt_q + CNT_ONE;
            2'b01:   cnt_d = cnt_q - CNT_ONE;
            default: cnt_d = cnt_q;
        endcase
        in_rdy_d = (cnt_d < CNT_NF);
    end

    // FIFO control state; ready is held low throughout reset
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            in_rdy_q <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            in_rdy_q <= in_rdy_d;
        end
    end

    // FIFO storage; contents need no reset since the pointers define validity
    always_ff @(posedge clk) begin
        if (wr_en) fifo_mem[wr_ptr_q] <= in_beat;
    end

    // ---------------- classification of the head beat ----------------
    logic           l3_ok, hit, tgt_drop;
    logic [15:0]    dport;
    logic [CHW-1:0] hit_ch, tgt_ch;

    // Lowest enabled table entry matching the destination port wins (descending scan)
    always_comb begin
        l3_ok  = (CHK_L3 == 0) ||
                 ((head.data[111:96] == 16'h0008) && (head.data[191:184] == 8'h11));
        dport  = head.data[335:320];
        hit    = 1'b0;
        hit_ch = '0;
        for (int j = NUM_CH - 2; j >= 0; j--) begin
            if (cfg_en[j] && (cfg_port[j*16 +: 16] == dport)) begin
                hit    = 1'b1;
                hit_ch = CHW'(j + 1);
            end
        end
        tgt_drop = l3_ok && !hit && (DROP_UNMATCHED != 0);
        tgt_ch   = (l3_ok && hit) ? hit_ch : '0;
    end

    // ---------------- steering FSM ----------------
    state_t            state_q, state_d;
    logic [CHW-1:0]    sel_q, sel_d;
    logic [NUM_CH-1:0] out_vld_q, out_vld_d, ch_free;
    beat_t             out_dat_q [NUM_CH];
    beat_t             out_dat_d [NUM_CH];
    logic              ld_en, drop_inc;
    logic [CHW-1:0]    ld_ch;
    logic [31:0]       drop_cnt_q, drop_cnt_d;

    // An output register can take a beat when empty or handing its beat off this cycle
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            ch_free[i] = !out_vld_q[i] || axis.m_axis_tready[i];
        end
    end

    // Next state and pop/load decisions; the table is consulted only in IDLE
    always_comb begin
        state_d  = state_q;
        sel_d    = sel_q;
        pop      = 1'b0;
        ld_en    = 1'b0;
        ld_ch    = sel_q;
        drop_inc = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (not_empty) begin
                    if (tgt_drop) begin
                        pop      = 1'b1;
                        drop_inc = 1'b1;
                        if (!head.last) state_d = S_DROP;
                    end else if (ch_free[tgt_ch]) begin
                        pop   = 1'b1;
                        ld_en = 1'b1;
                        ld_ch = tgt_ch;
                        if (!head.last) begin
                            state_d = S_FWD;
                            sel_d   = tgt_ch;
                        end
                    end
                end
            end
            S_FWD: begin
                if (not_empty && ch_free[sel_q]) begin
                    pop   = 1'b1;
                    ld_en = 1'b1;
                    ld_ch = sel_q;
                    if (head.last) state_d = S_IDLE;
                end
            end
            S_DROP: begin
                if (not_empty) begin
                    pop = 1'b1;
                    if (head.last) state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Output registers: load on steer, clear on handoff without reload, else hold
    always_comb begin
        drop_cnt_d = (drop_inc && (drop_cnt_q != 32'hFFFF_FFFF)) ? drop_cnt_q + 32'd1 : drop_cnt_q;
        for (int i = 0; i < NUM_CH; i++) begin
            out_vld_d[i] = out_vld_q[i];
            out_dat_d[i] = out_dat_q[i];
            if (ld_en && (ld_ch == CHW'(i))) begin
                out_vld_d[i] = 1'b1;
                out_dat_d[i] = head;
            end else if (axis.m_axis_tready[i]) begin
                out_vld_d[i] = 1'b0;
            end
        end
    end

    // FSM, channel select, output registers and drop counter
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            state_q    <= S_IDLE;
            sel_q      <= '0;
            out_vld_q  <= '0;
            drop_cnt_q <= '0;
            for (int i = 0; i < NUM_CH; i++) out_dat_q[i] <= '0;
        end else begin
            state_q    <= state_d;
            sel_q      <= sel_d;
            out_vld_q  <= out_vld_d;
            drop_cnt_q <= drop_cnt_d;
            for (int i = 0; i < NUM_CH; i++) out_dat_q[i] <= out_dat_d[i];
        end
    end

    // Pack the per-channel registers onto the flat output buses
    logic [NUM_CH*W-1:0] m_tdata;
    logic [NUM_CH*K-1:0] m_tkeep;
    logic [NUM_CH*U-1:0] m_tuser;
    logic [NUM_CH-1:0]   m_tlast;

    // Channel i occupies slice [i*width +: width]
    always_comb begin
        m_tdata = '0;
        m_tkeep = '0;
        m_tuser = '0;
        m_tlast = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            m_tdata[i*W +: W] = out_dat_q[i].data;
            m_tkeep[i*K +: K] = out_dat_q[i].keep;
            m_tuser[i*U +: U] = out_dat_q[i].user;
            m_tlast[i]        = out_dat_q[i].last;
        end
    end

    assign axis.m_axis_tdata  = m_tdata;
    assign axis.m_axis_tkeep  = m_tkeep;
    assign axis.m_axis_tuser  = m_tuser;
    assign axis.m_axis_tlast  = m_tlast;
    assign axis.m_axis_tvalid = out_vld_q;
    assign drop_cnt           = drop_cnt_q;
endmodule

// File: tb/tb_pkt_port_steer.sv
// Directed bench for pkt_port_steer: vector table of single packets plus latency, back-to-back, stall and reset sequences.
// Latency: checks 2-cycle handshake-to-tvalid on an idle steerer.
// Backpressure: stalls channel 2 long enough to fill the 16-deep input FIFO.
module tb_pkt_port_steer;
    localparam logic [15:0] ET_IP  = 16'h0008;
    localparam logic [7:0]  PR_UDP = 8'h11;

    typedef struct packed {
        logic         last;
        logic [63:0]  keep;
        logic [127:0] user;
        logic [511:0] data;
    } tbeat_t;

    typedef struct {
        logic [2:0]  en;
        logic [15:0] p0, p1, p2;
        logic [15:0] et;
        logic [7:0]  pr;
        logic [15:0] dp;
        int          nb;
        int          ch;   // 4 = dropped
        int          dd;   // expected drop_cnt delta
    } vec_t;

    logic        clk = 1'b0;
    logic        aresetn;
    logic [47:0] cfg_port;
    logic [2:0]  cfg_en;
    logic [31:0] drop_cnt;

    pkt_port_steer_if #(.DATA_W(512), .USER_W(128), .NUM_CH(4)) bus();

    pkt_port_steer #(
        .C_S_AXIS_DATA_WIDTH(512), .C_S_AXIS_TUSER_WIDTH(128), .NUM_CH(4),
        .FIFO_DEPTH_BITS(4), .CHK_L3(1), .DROP_UNMATCHED(1)
    ) dut (
        .clk(clk), .aresetn(aresetn), .axis(bus),
        .cfg_port(cfg_port), .cfg_en(cfg_en), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    int     cyc = 0;
    int     n_cmp = 0;
    int     n_err = 0;
    int     seq = 1;
    int     exp_drops = 0;
    int     rx_cyc [1024];
    tbeat_t exp_q [4][$];
    vec_t   vecs [11];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    function automatic tbeat_t mk(input int s, input logic [15:0] et, input logic [7:0] pr,
                                  input logic [15:0] dp, input logic last);
        tbeat_t      b;
        logic [31:0] sv;
        sv = s;
        b.data = {16{sv}};
        b.data[111:96]  = et;
        b.data[191:184] = pr;
        b.data[335:320] = dp;
        b.keep = {2{~sv}};
        b.user = {4{sv ^ 32'h5a5a_0f0f}};
        b.last = last;
        return b;
    endfunction

    function automatic tbeat_t get_out(input int i);
        tbeat_t b;
        b.data = bus.m_axis_tdata[i*512 +: 512];
        b.keep = bus.m_axis_tkeep[i*64 +: 64];
        b.user = bus.m_axis_tuser[i*128 +: 128];
        b.last = bus.m_axis_tlast[i];
        return b;
    endfunction

    // Scoreboard: every output handshake must match the next expected beat of that channel
    always @(negedge clk) begin
        if (aresetn) begin
            for (int i = 0; i < 4; i++) begin
                if (bus.m_axis_tvalid[i] && bus.m_axis_tready[i]) begin
                    tbeat_t got, e;
                    got = get_out(i);
                    rx_cyc[got.data[9:0]] = cyc;
                    n_cmp++;
                    if (exp_q[i].size() == 0) begin
                        n_err++;
                        $display("FAIL ch%0d_unexpected: got seq %0d, expected no beat", i, got.data[31:0]);
                    end else begin
                        e = exp_q[i].pop_front();
                        if (got !== e) begin
                            n_err++;
                            $display("FAIL ch%0d_beat: got seq %0d last %0b keep %0h, expected seq %0d last %0b keep %0h",
                                     i, got.data[31:0], got.last, got.keep, e.data[31:0], e.last, e.keep);
                        end
                    end
                end
            end
        end
    end

    task automatic send_beat(input tbeat_t b, output int hcyc);
        int  t;
        logic hs;
        t = 0;
        hcyc = -1;
        bus.s_axis_tdata  = b.data;
        bus.s_axis_tkeep  = b.keep;
        bus.s_axis_tuser  = b.user;
        bus.s_axis_tlast  = b.last;
        bus.s_axis_tvalid = 1'b1;
        forever begin
            hs   = bus.s_axis_tready;
            hcyc = cyc;
            @(posedge clk);
            #1;
            if (hs) break;
            t++;
            if (t > 500) begin
                chk("send_timeout", 64'(t), 64'd0);
                break;
            end
        end
    endtask

    task automatic send_pkt(input logic [15:0] et, input logic [7:0] pr, input logic [15:0] dp,
                            input int nb, input int ch, output int hs0, output int s0);
        tbeat_t bt;
        int     h;
        s0  = seq;
        hs0 = -1;
        for (int b = 0; b < nb; b++) begin
            bt = mk(seq, et, pr, dp, (b == nb - 1));
            if (ch < 4) exp_q[ch].push_back(bt);
            seq++;
            send_beat(bt, h);
            if (b == 0) hs0 = h;
        end
        bus.s_axis_tvalid = 1'b0;
    endtask

    task automatic wait_drain(input string nm);
        int t;
        t = 0;
        while ((exp_q[0].size() + exp_q[1].size() + exp_q[2].size() + exp_q[3].size()) != 0 && t < 300) begin
            @(posedge clk);
            #1;
            t++;
        end
        repeat (3) @(posedge clk);
        #1;
        chk(nm, 64'(exp_q[0].size() + exp_q[1].size() + exp_q[2].size() + exp_q[3].size()), 64'd0);
    endtask

    initial begin
        int     hs, s0, s1, s2, d0, t;
        logic   rdy_low;
        tbeat_t snap;

        vecs[0]  = '{3'b010, 16'h1111, 16'heeee, 16'h3333, ET_IP,    PR_UDP, 16'heeee, 3, 2, 0};
        vecs[1]  = '{3'b010, 16'h1111, 16'heeee, 16'h3333, 16'h0608, PR_UDP, 16'heeee, 2, 0, 0};
        vecs[2]  = '{3'b010, 16'h1111, 16'heeee, 16'h3333, ET_IP,    PR_UDP, 16'h1234, 1, 4, 1};
        vecs[3]  = '{3'b010, 16'h1111, 16'heeee, 16'h3333, ET_IP,    PR_UDP, 16'h1234, 3, 4, 1};
        vecs[4]  = '{3'b010, 16'h1111, 16'heeee, 16'h3333, ET_IP,    8'h06,  16'heeee, 1, 0, 0};
        vecs[5]  = '{3'b111, 16'heeee, 16'heeee, 16'heeee, ET_IP,    PR_UDP, 16'heeee, 2, 1, 0};
        vecs[6]  = '{3'b110, 16'heeee, 16'heeee, 16'heeee, ET_IP,    PR_UDP, 16'heeee, 1, 2, 0};
        vecs[7]  = '{3'b100, 16'h1111, 16'h2222, 16'h3333, ET_IP,    PR_UDP, 16'h3333, 2, 3, 0};
        vecs[8]  = '{3'b011, 16'h1111, 16'h2222, 16'h3333, ET_IP,    PR_UDP, 16'h3333, 1, 4, 1};
        vecs[9]  = '{3'b111, 16'h1111, 16'h2222, 16'h3333, 16'h0800, PR_UDP, 16'h2222, 1, 0, 0};
        vecs[10] = '{3'b001, 16'h0000, 16'h2222, 16'h3333, ET_IP,    PR_UDP, 16'h0000, 1, 1, 0};

        aresetn = 1'b0;
        bus.s_axis_tvalid = 1'b0;
        bus.s_axis_tdata  = '0;
        bus.s_axis_tkeep  = '0;
        bus.s_axis_tuser  = '0;
        bus.s_axis_tlast  = 1'b0;
        bus.m_axis_tready = 4'hF;
        cfg_en   = '0;
        cfg_port = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_s_tready", 64'(bus.s_axis_tready), 64'd0);
        chk("rst_m_tvalid", 64'(bus.m_axis_tvalid), 64'd0);
        chk("rst_m_tdata_or", 64'(|bus.m_axis_tdata), 64'd0);
        chk("rst_m_tlast", 64'(bus.m_axis_tlast), 64'd0);
        chk("rst_drop_cnt", 64'(drop_cnt), 64'd0);
        @(negedge clk);
        aresetn = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("s_tready_after_rst", 64'(bus.s_axis_tready), 64'd1);

        // Table of single packets
        for (int k = 0; k < 11; k++) begin
            cfg_en   = vecs[k].en;
            cfg_port = {vecs[k].p2, vecs[k].p1, vecs[k].p0};
            d0 = drop_cnt;
            send_pkt(vecs[k].et, vecs[k].pr, vecs[k].dp, vecs[k].nb, vecs[k].ch, hs, s0);
            wait_drain($sformatf("v%0d_drain", k));
            chk($sformatf("v%0d_drop_delta", k), 64'(drop_cnt - d0), 64'(vecs[k].dd));
            exp_drops += vecs[k].dd;
        end

        // 3-beat UDP packet to channel 2: latency and single-channel delivery
        cfg_en   = 3'b010;
        cfg_port = {16'h3333, 16'heeee, 16'h1111};
        send_pkt(ET_IP, PR_UDP, 16'heeee, 3, 2, hs, s0);
        wait_drain("lat_drain");
        chk("lat_first_tvalid", 64'(rx_cyc[s0 % 1024]), 64'(hs + 2));
        chk("lat_beat3_next", 64'(rx_cyc[(s0 + 2) % 1024]), 64'(hs + 4));

        // Back-to-back single-beat packets to channels 1, 3, 0
        cfg_en   = 3'b111;
        cfg_port = {16'hcccc, 16'hbbbb, 16'haaaa};
        send_pkt(ET_IP, PR_UDP, 16'haaaa, 1, 1, hs, s0);
        send_pkt(ET_IP, PR_UDP, 16'hcccc, 1, 3, t, s1);
        send_pkt(16'h0608, PR_UDP, 16'hbbbb, 1, 0, t, s2);
        wait_drain("b2b_drain");
        chk("b2b_first", 64'(rx_cyc[s0 % 1024]), 64'(hs + 2));
        chk("b2b_second", 64'(rx_cyc[s1 % 1024]), 64'(hs + 3));
        chk("b2b_third", 64'(rx_cyc[s2 % 1024]), 64'(hs + 4));

        // 40-beat packet to channel 2 with a 20-cycle sink stall and a mid-packet table change
        cfg_en   = 3'b010;
        cfg_port = {16'h3333, 16'heeee, 16'h1111};
        bus.m_axis_tready[2] = 1'b0;
        rdy_low = 1'b0;
        fork
            send_pkt(ET_IP, PR_UDP, 16'heeee, 40, 2, hs, s0);
            begin
                t = 0;
                while (!bus.m_axis_tvalid[2] && t < 100) begin
                    @(posedge clk);
                    #2;
                    t++;
                end
                chk("stall_vld", 64'(bus.m_axis_tvalid[2]), 64'd1);
                snap = get_out(2);
                for (int k = 0; k < 20; k++) begin
                    @(posedge clk);
                    #2;
                    if (!bus.s_axis_tready) rdy_low = 1'b1;
                    if (k == 5) begin
                        cfg_en   = 3'b000;
                        cfg_port = '0;
                    end
                    n_cmp++;
                    if (get_out(2) !== snap || bus.m_axis_tvalid[2] !== 1'b1) begin
                        n_err++;
                        $display("FAIL stall_hold_%0d: got seq %0d vld %0b, expected seq %0d vld 1",
                                 k, bus.m_axis_tdata[2*512 +: 32], bus.m_axis_tvalid[2], snap.data[31:0]);
                    end
                end
                chk("stall_s_tready_fell", 64'(rdy_low), 64'd1);
                bus.m_axis_tready[2] = 1'b1;
            end
        join
        wait_drain("stall_drain");

        // Reset in the middle of a packet sitting in channel 2
        cfg_en   = 3'b010;
        cfg_port = {16'h3333, 16'heeee, 16'h1111};
        bus.m_axis_tready = 4'h0;
        send_beat(mk(seq, ET_IP, PR_UDP, 16'heeee, 1'b0), t);
        seq++;
        send_beat(mk(seq, ET_IP, PR_UDP, 16'heeee, 1'b0), t);
        seq++;
        bus.s_axis_tvalid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("pre_rst_vld2", 64'(bus.m_axis_tvalid), 64'h4);
        chk("pre_rst_drops", 64'(drop_cnt), 64'(exp_drops));
        @(negedge clk);
        #2;
        aresetn = 1'b0;
        #1;
        chk("mid_rst_tvalid", 64'(bus.m_axis_tvalid), 64'd0);
        chk("mid_rst_tdata_or", 64'(|bus.m_axis_tdata), 64'd0);
        chk("mid_rst_tkeep_or", 64'(|bus.m_axis_tkeep), 64'd0);
        chk("mid_rst_tuser_or", 64'(|bus.m_axis_tuser), 64'd0);
        chk("mid_rst_tlast", 64'(bus.m_axis_tlast), 64'd0);
        chk("mid_rst_s_tready", 64'(bus.s_axis_tready), 64'd0);
        chk("mid_rst_drop_cnt", 64'(drop_cnt), 64'd0);
        bus.m_axis_tready = 4'hF;
        repeat (2) @(posedge clk);
        @(negedge clk);
        aresetn = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        cfg_en   = 3'b100;
        cfg_port = {16'h3333, 16'h2222, 16'h1111};
        send_pkt(ET_IP, PR_UDP, 16'h3333, 2, 3, hs, s0);
        wait_drain("post_rst_drain");
        chk("post_rst_latency", 64'(rx_cyc[s0 % 1024]), 64'(hs + 2));
        chk("post_rst_drop_cnt", 64'(drop_cnt), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/pkt_port_steer.md
PKT_PORT_STEER -- requirements
Module: pkt_port_steer

Interface
REQ-001 C_S_AXIS_DATA_WIDTH, 512, data width in bits (W), multiple of 8, at least 512.
REQ-002 C_S_AXIS_TUSER_WIDTH, 128, tuser width (U).
REQ-003 NUM_CH, 4, output channel count (N, 2..8); channel 0 is the default path.
REQ-004 FIFO_DEPTH_BITS, 5, input FIFO depth is 2^FIFO_DEPTH_BITS beats.
REQ-005 CHK_L3, 1, when 1, a packet is steerable only if ethertype and protocol match.
REQ-006 DROP_UNMATCHED, 0, when 1, steerable packets with no table hit are dropped instead of going to channel 0.
REQ-007 clk  in  1  single clock; all logic is on its rising edge.
REQ-008 aresetn  in  1  reset, asynchronous and active-low.
REQ-009 s_axis_tdata/tkeep/tuser/tvalid/tlast  in  W/W/8/U/1/1  input stream; s_axis_tready  out  1.
REQ-010 m_axis_tdata  out  N*W; m_axis_tkeep  out  N*W/8; m_axis_tuser  out  N*U; m_axis_tvalid/tlast  out  N each; m_axis_tready  in  N.
REQ-011 Each output bus packs channel i at slice [i*width +: width].
REQ-012 cfg_port  in  (N-1)*16  steering table; entry j (16 bits) targets channel j+1.
REQ-013 cfg_en  in  N-1  per-entry enable.
REQ-014 drop_cnt  out  32  count of dropped packets.

Function
REQ-015 Input beats enter a first-word-fallthrough FIFO; s_axis_tready = !nearly_full; a beat is written only on tvalid&&tready.
REQ-016 States: IDLE (head is a first beat), FWD (forward to the latched channel sel), DROP (discard).
REQ-017 Header fields use raw lane values: ethertype [111:96] == 16'h0008, protocol [191:184] == 8'h11, dst port [335:320].
REQ-018 Classification in IDLE with FIFO non-empty: if CHK_L3 and either field mismatches, target = 0.
REQ-019 Otherwise target = j+1 for the lowest enabled j with cfg_port[j] == dst port.
REQ-020 Otherwise target = DROP if DROP_UNMATCHED, else 0.
REQ-021 The table is sampled only on the first beat; config changes never affect a packet in flight.
REQ-022 Each channel has one output register, free when !m_axis_tvalid[i] || m_axis_tready[i].
REQ-023 A beat is popped only when the target register is free; pop and load occur in the same cycle.
REQ-024 m_axis_tvalid[i] rises on the next edge; other channels are unaffected.
REQ-025 If the target register is not free, stay in IDLE, do not pop, and reclassify every cycle.
REQ-026 While tvalid[i]=1 and tready[i]=0, all channel-i outputs hold stable.
REQ-027 tvalid[i] clears on a handshake with no new load.
REQ-028 A free register accepts a new beat in the cycle it hands one off, giving 1 beat/cycle throughput.
REQ-029 First beat without tlast: IDLE->FWD with target latched into sel, or IDLE->DROP.
REQ-030 FWD pops when reg[sel] is free and returns to IDLE after popping the tlast beat.
REQ-031 A single-beat packet (tlast on the first beat) stays in IDLE and is forwarded or dropped in one pop.
REQ-032 DROP pops one beat per cycle while the FIFO is non-empty, independent of any tready, and returns to IDLE after tlast.
REQ-033 drop_cnt increments once per dropped packet, on its first-beat pop, and saturates at 32'hFFFFFFFF.
REQ-034 Latency: s_axis handshake to m_axis_tvalid is 2 cycles when idle and unblocked.
REQ-035 tdata, tkeep, tuser and tlast pass through unmodified; packet order is preserved per channel.
REQ-036 An unclassified channel-0 packet may be blocked behind a stalled channel (head-of-line); this is accepted.

Reset
REQ-037 aresetn low asynchronously forces: state IDLE, FIFO empty, every m_axis_* output 0, drop_cnt 0, sel 0, s_axis_tready 0 while asserted.
REQ-038 Reset mid-packet discards all partial data; the first beat accepted after release is treated as a header.
REQ-039 Restoring the framing of upstream packets cut by reset is the source's responsibility.

Verification
REQ-040 N=4, cfg_en=3'b010, cfg_port[1]=16'heeee; 3-beat IPv4/UDP packet with dst port 16'heeee -> appears only on channel 2, first tvalid 2 cycles after the first handshake, tlast on beat 3.
REQ-041 Non-IPv4 packet (ethertype 16'h0608) with port 16'heeee, CHK_L3=1 -> channel 0; drop_cnt unchanged.
REQ-042 DROP_UNMATCHED=1; UDP packet with port 16'h1234 and no enabled match -> no tvalid on any channel; drop_cnt 0->1.
REQ-043 Channel 2 tready held 0 for 20 cycles during a 40-beat packet -> channel-2 outputs stable; s_axis_tready falls at FIFO nearly-full; zero beats lost or duplicated after release.
REQ-044 Back-to-back single-beat packets to channels 1, 3, 0 with all tready=1 -> one beat per cycle, each on its own channel.
REQ-045 aresetn pulsed low mid-packet -> all outputs 0 within the same cycle; a following well-formed packet is steered correctly.
